// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings, datapath width and opcode helpers shared by
//                the execute stage and the ALU16b core.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_W = 16;
  localparam int OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_NOR = 3'd2;
  localparam logic [OP_W-1:0] OP_ADD = 3'd3;
  localparam logic [OP_W-1:0] OP_SUB = 3'd4;
  localparam logic [OP_W-1:0] OP_SLT = 3'd5;

  // Only ADD and SUB may report overflow to writeback.
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Encodings 6 and 7 are not defined.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_alu16b.sv
`default_nettype none
// ============================================================================
//  Module      : ALU16b
//  Description : Purely combinational 16-bit ALU. AND/OR/NOR/ADD/SUB/SLT on
//                two's-complement operands. One shared adder serves ADD, SUB
//                and SLT; ovfl is the signed overflow of that adder and is
//                only meaningful for ADD/SUB (the caller masks it).
//  Revision    : 1.0 - initial release
// ============================================================================
module ALU16b
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_r,
  output logic             o_zero,
  output logic             o_ovfl
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_lt;

  // SUB and SLT subtract via a + ~b + 1; everything else feeds b straight in.
  assign w_sub   = (i_op == OP_SUB) || (i_op == OP_SLT);
  assign w_b_eff = w_sub ? ~i_b : i_b;
  assign w_cin   = {{(WIDTH-1){1'b0}}, w_sub};
  assign w_sum   = i_a + w_b_eff + w_cin;

  // Signed overflow: addends agree in sign but the sum does not.
  assign w_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  // Signed less-than is the true sign of a-b, i.e. the sum sign corrected by overflow.
  assign w_lt = w_sum[WIDTH-1] ^ w_ovf;

  // Result select by opcode; undefined opcodes yield zero.
  always_comb begin
    o_r = '0;
    case (i_op)
      OP_AND:  o_r = i_a & i_b;
      OP_OR:   o_r = i_a | i_b;
      OP_NOR:  o_r = ~(i_a | i_b);
      OP_ADD:  o_r = w_sum;
      OP_SUB:  o_r = w_sum;
      OP_SLT:  o_r = {{(WIDTH-1){1'b0}}, w_lt};
      default: o_r = '0;
    endcase
  end

  assign o_zero = (o_r == '0);
  assign o_ovfl = w_ovf;

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute stage around ALU16b. Accepts one bundle per cycle over
//                valid/ready, registers {r, zero, ovfl, rd} toward writeback,
//                and absorbs back-pressure in a one-entry skid register so that
//                in_ready can be driven from a flop. Also keeps a sticky
//                overflow bit and pulses illegal_op for opcodes 6/7.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_r,
  output logic             out_zero,
  output logic             out_ovfl,
  output logic [RD_W-1:0]  out_rd,
  output logic             illegal_op,
  output logic             ovfl_sticky,
  input  logic             ovfl_clear
);

  // Occupancy: EMPTY = nothing held, ONE = output reg valid, FULL = output and skid valid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_xfer;
  logic             w_load_out_in;
  logic             w_load_out_skid;
  logic             w_load_skid;

  logic [WIDTH-1:0] w_alu_r;
  logic             w_alu_zero;
  logic             w_alu_ovfl;
  logic             w_legal;
  logic [WIDTH-1:0] w_res_r;
  logic             w_res_zero;
  logic             w_res_ovfl;

  logic [WIDTH-1:0] r_out_r;
  logic             r_out_zero;
  logic             r_out_ovfl;
  logic [RD_W-1:0]  r_out_rd;
  logic [WIDTH-1:0] r_skid_r;
  logic             r_skid_zero;
  logic             r_skid_ovfl;
  logic [RD_W-1:0]  r_skid_rd;
  logic             r_illegal;
  logic             r_sticky;

  ALU16b #(
    .WIDTH (WIDTH)
  ) u_alu (
    .i_a    (in_a),
    .i_b    (in_b),
    .i_op   (in_op),
    .o_r    (w_alu_r),
    .o_zero (w_alu_zero),
    .o_ovfl (w_alu_ovfl)
  );

  // Illegal opcodes travel as an all-zero bundle; the ALU result already is
  // zero for them but its zero flag would read 1, so that flag is forced low.
  assign w_legal    = op_is_legal(in_op);
  assign w_res_r    = w_legal ? w_alu_r : '0;
  assign w_res_zero = w_legal & w_alu_zero;
  assign w_res_ovfl = op_is_arith(in_op) & w_alu_ovfl;

  assign w_accept = in_valid & r_in_ready;
  assign w_xfer   = out_valid & out_ready;

  // State register; in_ready is registered from the next state so it is low
  // throughout reset and rises on the first cycle after.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Next-state decode from accept/transfer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_ONE;
      ST_ONE: begin
        if (w_accept && !w_xfer)      w_state_nxt = ST_FULL;
        else if (!w_accept && w_xfer) w_state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (w_xfer) w_state_nxt = ST_ONE;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  // Datapath load enables per state.
  always_comb begin
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_out_in = w_accept;
      ST_ONE: begin
        w_load_out_in = w_accept & w_xfer;
        w_load_skid   = w_accept & ~w_xfer;
      end
      ST_FULL:  w_load_out_skid = w_xfer;
      default: begin
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
      end
    endcase
  end

  // Output register: loads from the ALU or drains the skid; holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_r    <= '0;
      r_out_zero <= 1'b0;
      r_out_ovfl <= 1'b0;
      r_out_rd   <= '0;
    end else if (w_load_out_in) begin
      r_out_r    <= w_res_r;
      r_out_zero <= w_res_zero;
      r_out_ovfl <= w_res_ovfl;
      r_out_rd   <= in_rd;
    end else if (w_load_out_skid) begin
      r_out_r    <= r_skid_r;
      r_out_zero <= r_skid_zero;
      r_out_ovfl <= r_skid_ovfl;
      r_out_rd   <= r_skid_rd;
    end
  end

  // Skid register: catches the bundle accepted while the output is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_r    <= '0;
      r_skid_zero <= 1'b0;
      r_skid_ovfl <= 1'b0;
      r_skid_rd   <= '0;
    end else if (w_load_skid) begin
      r_skid_r    <= w_res_r;
      r_skid_zero <= w_res_zero;
      r_skid_ovfl <= w_res_ovfl;
      r_skid_rd   <= in_rd;
    end
  end

  // Status flops: one-cycle illegal pulse, and sticky overflow where set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
      r_sticky  <= 1'b0;
    end else begin
      r_illegal <= w_accept & ~w_legal;
      if (w_accept && w_res_ovfl) r_sticky <= 1'b1;
      else if (ovfl_clear)        r_sticky <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_r       = r_out_r;
  assign out_zero    = r_out_zero;
  assign out_ovfl    = r_out_ovfl;
  assign out_rd      = r_out_rd;
  assign illegal_op  = r_illegal;
  assign ovfl_sticky = r_sticky;

endmodule
`default_nettype wire
